// File: rtl/apb_master_arbiter_if.sv
// Requester handshakes plus APB bus signals for apb_master_arbiter.
// master: the arbiter side; slave: the requesters and the APB target.
interface apb_master_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic                  req0_valid;
  logic                  req0_write;
  logic [ADDR_WIDTH-1:0] req0_addr;
  logic [DATA_WIDTH-1:0] req0_wdata;
  logic                  req0_ready;
  logic                  rsp0_valid;
  logic [DATA_WIDTH-1:0] rsp0_rdata;
  logic                  rsp0_err;
  logic                  req1_valid;
  logic                  req1_write;
  logic [ADDR_WIDTH-1:0] req1_addr;
  logic [DATA_WIDTH-1:0] req1_wdata;
  logic                  req1_ready;
  logic                  rsp1_valid;
  logic [DATA_WIDTH-1:0] rsp1_rdata;
  logic                  rsp1_err;
  logic                  PSELx;
  logic                  PENABLE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic                  PWRITE;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic                  PREADY;
  logic [DATA_WIDTH-1:0] PRDATA;

  modport master (
    input  req0_valid, req0_write, req0_addr, req0_wdata,
           req1_valid, req1_write, req1_addr, req1_wdata,
           PREADY, PRDATA,
    output req0_ready, rsp0_valid, rsp0_rdata, rsp0_err,
           req1_ready, rsp1_valid, rsp1_rdata, rsp1_err,
           PSELx, PENABLE, PADDR, PWRITE, PWDATA
  );

  modport slave (
    output req0_valid, req0_write, req0_addr, req0_wdata,
           req1_valid, req1_write, req1_addr, req1_wdata,
           PREADY, PRDATA,
    input  req0_ready, rsp0_valid, rsp0_rdata, rsp0_err,
           req1_ready, rsp1_valid, rsp1_rdata, rsp1_err,
           PSELx, PENABLE, PADDR, PWRITE, PWDATA
  );
endinterface

// File: rtl/apb_master_arbiter.sv
// Two-requester round-robin APB master sequencing IDLE/SETUP/ACCESS.
// Define APB_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES wait states.
module apb_master_arbiter #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic                  PCLK,
  input logic                  PRESETn,
  apb_master_arbiter_if.master bus
);
  // state  | meaning
  // IDLE   | bus idle, accepting requests
  // SETUP  | PSELx=1, PENABLE=0, captured request on the bus
  // ACCESS | PSELx=1, PENABLE=1, waiting for PREADY
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_last_grant;
  logic                  r_owner;
  logic                  r_write;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_psel;
  logic                  r_penable;
  logic                  r_rsp0_valid;
  logic                  r_rsp1_valid;
  logic [DATA_WIDTH-1:0] r_rsp0_rdata;
  logic [DATA_WIDTH-1:0] r_rsp1_rdata;
  logic                  w_window;
  logic                  w_sel0;
  logic                  w_sel1;
  logic                  w_ready0;
  logic                  w_ready1;
  logic                  w_accept;
  logic                  w_done;
  logic                  w_timeout;
  logic                  w_end;

  // On a tie the requester that did not win last time is selected.
  assign w_window = (r_state == ST_IDLE) || ((r_state == ST_ACCESS) && bus.PREADY);
  assign w_sel0   = bus.req0_valid && (!bus.req1_valid || r_last_grant);
  assign w_sel1   = bus.req1_valid && (!bus.req0_valid || !r_last_grant);
  assign w_ready0 = PRESETn && w_window && w_sel0;
  assign w_ready1 = PRESETn && w_window && w_sel1;
  assign w_accept = w_ready0 || w_ready1;
  assign w_done   = (r_state == ST_ACCESS) && bus.PREADY;
  assign w_end    = w_done || w_timeout;

`ifdef APB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_wait_cnt;
  logic             r_rsp0_err;
  logic             r_rsp1_err;

  // PREADY on the terminal cycle still completes normally.
  assign w_timeout = (r_state == ST_ACCESS) && !bus.PREADY &&
                     (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      r_wait_cnt <= '0;
      r_rsp0_err <= 1'b0;
      r_rsp1_err <= 1'b0;
    end else begin
      if (r_state == ST_SETUP)
        r_wait_cnt <= '0;
      else if ((r_state == ST_ACCESS) && !bus.PREADY)
        r_wait_cnt <= r_wait_cnt + 1'b1;
      if (w_end && !r_owner) r_rsp0_err <= w_timeout;
      if (w_end && r_owner)  r_rsp1_err <= w_timeout;
    end
  end

  assign bus.rsp0_err = r_rsp0_err;
  assign bus.rsp1_err = r_rsp1_err;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYCLES > 0);
  assign w_timeout        = 1'b0;
  assign bus.rsp0_err     = 1'b0;
  assign bus.rsp1_err     = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_accept) w_state_nxt = ST_SETUP;
      ST_SETUP:  w_state_nxt = ST_ACCESS;
      ST_ACCESS: begin
        if (w_done)         w_state_nxt = w_accept ? ST_SETUP : ST_IDLE;
        else if (w_timeout) w_state_nxt = ST_IDLE;
      end
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      r_state      <= ST_IDLE;
      r_last_grant <= 1'b1;
      r_owner      <= 1'b0;
      r_write      <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_psel       <= 1'b0;
      r_penable    <= 1'b0;
      r_rsp0_valid <= 1'b0;
      r_rsp1_valid <= 1'b0;
      r_rsp0_rdata <= '0;
      r_rsp1_rdata <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_psel    <= (w_state_nxt != ST_IDLE);
      r_penable <= (w_state_nxt == ST_ACCESS);
      if (w_accept) begin
        r_owner      <= w_ready1;
        r_last_grant <= w_ready1;
        r_write      <= w_ready1 ? bus.req1_write : bus.req0_write;
        r_addr       <= w_ready1 ? bus.req1_addr  : bus.req0_addr;
        r_wdata      <= w_ready1 ? bus.req1_wdata : bus.req0_wdata;
      end
      // r_owner still names the finishing transfer even if a new one is captured now.
      r_rsp0_valid <= w_end && !r_owner;
      r_rsp1_valid <= w_end && r_owner;
      if (w_end && !r_owner) r_rsp0_rdata <= (r_write || w_timeout) ? '0 : bus.PRDATA;
      if (w_end && r_owner)  r_rsp1_rdata <= (r_write || w_timeout) ? '0 : bus.PRDATA;
    end
  end

  assign bus.req0_ready = w_ready0;
  assign bus.req1_ready = w_ready1;
  assign bus.rsp0_valid = r_rsp0_valid;
  assign bus.rsp1_valid = r_rsp1_valid;
  assign bus.rsp0_rdata = r_rsp0_rdata;
  assign bus.rsp1_rdata = r_rsp1_rdata;
  assign bus.PSELx      = r_psel;
  assign bus.PENABLE    = r_penable;
  assign bus.PADDR      = r_addr;
  assign bus.PWRITE     = r_write;
  assign bus.PWDATA     = r_wdata;
endmodule

// File: tb/tb_apb_master_arbiter.sv
// Scoreboard bench for apb_master_arbiter: random requesters, APB memory slave,
// and a transaction-level reference (sequential memory + round-robin rule).
module tb_apb_master_arbiter;
  localparam int DW = 8;
  localparam int AW = 4;

  typedef struct {
    logic          owner;
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } xfer_t;

  logic PCLK    = 1'b0;
  logic PRESETn = 1'b0;
  always #5 PCLK = ~PCLK;

  apb_master_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  apb_master_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(16)) dut (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .bus     (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // requester drivers and APB slave
  logic          d_valid [2];
  logic          d_write [2];
  logic [AW-1:0] d_addr  [2];
  logic [DW-1:0] d_wdata [2];
  logic          acc_flag [2];
  xfer_t         dq0 [$];
  xfer_t         dq1 [$];
  bit            rnd_en    = 1'b0;
  int            valid_pct = 60;
  int            ready_pct = 100;
  int            stall_n   = 0;
  int            acc_cyc   = 0;
  logic          pready    = 1'b1;
  logic [DW-1:0] seed_mem [1<<AW];
  logic [DW-1:0] slv_mem  [1<<AW];
  logic [DW-1:0] ref_mem  [1<<AW];
  bit            slv_init = 1'b0;

  assign bus.req0_valid = d_valid[0];
  assign bus.req0_write = d_write[0];
  assign bus.req0_addr  = d_addr[0];
  assign bus.req0_wdata = d_wdata[0];
  assign bus.req1_valid = d_valid[1];
  assign bus.req1_write = d_write[1];
  assign bus.req1_addr  = d_addr[1];
  assign bus.req1_wdata = d_wdata[1];
  assign bus.PREADY     = pready;
  assign bus.PRDATA     = slv_mem[bus.PADDR];

  always @(posedge PCLK) begin
    if (!slv_init) begin
      for (int i = 0; i < (1<<AW); i++) slv_mem[i] <= seed_mem[i];
      slv_init <= 1'b1;
    end else if (PRESETn && bus.PSELx && bus.PENABLE && bus.PREADY && bus.PWRITE)
      slv_mem[bus.PADDR] <= bus.PWDATA;
  end

  always @(posedge PCLK) begin
    xfer_t t;
    #1;
    for (int n = 0; n < 2; n++) begin
      if (d_valid[n] && acc_flag[n]) d_valid[n] = 1'b0;
      if (!d_valid[n]) begin
        if (n == 0 && dq0.size() > 0) begin
          t = dq0.pop_front();
          d_valid[n] = 1'b1; d_write[n] = t.write; d_addr[n] = t.addr; d_wdata[n] = t.wdata;
        end else if (n == 1 && dq1.size() > 0) begin
          t = dq1.pop_front();
          d_valid[n] = 1'b1; d_write[n] = t.write; d_addr[n] = t.addr; d_wdata[n] = t.wdata;
        end else if (rnd_en && ($urandom_range(0, 99) < valid_pct)) begin
          d_valid[n] = 1'b1;
          d_write[n] = 1'($urandom_range(0, 1));
          d_addr[n]  = AW'($urandom_range(0, (1<<AW) - 1));
          d_wdata[n] = DW'($urandom_range(0, 255));
        end
      end
    end
    if (bus.PSELx && bus.PENABLE) acc_cyc++;
    else                          acc_cyc = 0;
    if (acc_cyc != 0 && acc_cyc <= stall_n) pready = 1'b0;
    else                                    pready = ($urandom_range(0, 99) < ready_pct);
  end

  // monitor / scoreboard
  xfer_t         exp_q [$];
  xfer_t         p_x;
  bit            p_rst = 1'b1, p_acc = 1'b0, p_comp = 1'b0, p_wait = 1'b0, p_setup = 1'b0;
  logic [AW-1:0] s_addr;
  logic          s_write;
  logic [DW-1:0] s_wdata;
  logic          tb_last = 1'b1;

  always @(negedge PCLK) begin
    xfer_t         h;
    logic          e0, e1, win, sel0, sel1, a0, a1;
    logic [DW-1:0] ed;
    if (p_rst) begin
      chk("reset_bus_ctl",   {bus.PSELx, bus.PENABLE, bus.PWRITE}, 3'b000);
      chk("reset_paddr",     bus.PADDR, 0);
      chk("reset_pwdata",    bus.PWDATA, 0);
      chk("reset_rsp_valid", {bus.rsp0_valid, bus.rsp1_valid}, 2'b00);
      chk("reset_rsp_err",   {bus.rsp0_err, bus.rsp1_err}, 2'b00);
      chk("reset_rsp_rdata", {bus.rsp0_rdata, bus.rsp1_rdata}, 0);
      exp_q.delete();
    end else begin
      e0 = p_comp && exp_q.size() > 0 && exp_q[0].owner == 1'b0;
      e1 = p_comp && exp_q.size() > 0 && exp_q[0].owner == 1'b1;
      chk("rsp0_valid", bus.rsp0_valid, e0);
      chk("rsp1_valid", bus.rsp1_valid, e1);
      if (p_comp) begin
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL orphan_completion: bus completed with no accepted request outstanding (t=%0t)", $time);
        end else begin
          h  = exp_q.pop_front();
          ed = h.write ? '0 : ref_mem[h.addr];
          if (h.write) ref_mem[h.addr] = h.wdata;
          if (h.owner) chk("rsp1_rdata", bus.rsp1_rdata, ed);
          else         chk("rsp0_rdata", bus.rsp0_rdata, ed);
          chk("rsp_err", {bus.rsp0_err, bus.rsp1_err}, 2'b00);
        end
      end
      if (p_acc) begin
        chk("setup_ctl",    {bus.PSELx, bus.PENABLE}, 2'b10);
        chk("setup_paddr",  bus.PADDR, p_x.addr);
        chk("setup_pwrite", bus.PWRITE, p_x.write);
        if (p_x.write) chk("setup_pwdata", bus.PWDATA, p_x.wdata);
        exp_q.push_back(p_x);
      end else if (p_wait || p_setup) begin
        chk("access_ctl",  {bus.PSELx, bus.PENABLE}, 2'b11);
        chk("access_hold", {bus.PADDR, bus.PWRITE, bus.PWDATA}, {s_addr, s_write, s_wdata});
      end else begin
        chk("idle_ctl", {bus.PSELx, bus.PENABLE}, 2'b00);
      end
    end

    win  = !bus.PSELx || (bus.PENABLE && bus.PREADY);
    sel0 = bus.req0_valid && (!bus.req1_valid || tb_last == 1'b1);
    sel1 = bus.req1_valid && (!bus.req0_valid || tb_last == 1'b0);
    chk("req0_ready", bus.req0_ready, PRESETn && win && sel0);
    chk("req1_ready", bus.req1_ready, PRESETn && win && sel1);
    a0 = bus.req0_valid && bus.req0_ready;
    a1 = bus.req1_valid && bus.req1_ready;
    acc_flag[0] = a0;
    acc_flag[1] = a1;
    p_rst   = !PRESETn;
    p_acc   = PRESETn && (a0 || a1);
    if (a0)      p_x = '{1'b0, bus.req0_write, bus.req0_addr, bus.req0_wdata};
    else if (a1) p_x = '{1'b1, bus.req1_write, bus.req1_addr, bus.req1_wdata};
    p_comp  = PRESETn && bus.PSELx && bus.PENABLE && bus.PREADY;
    p_wait  = PRESETn && bus.PSELx && bus.PENABLE && !bus.PREADY;
    p_setup = PRESETn && bus.PSELx && !bus.PENABLE;
    s_addr  = bus.PADDR;
    s_write = bus.PWRITE;
    s_wdata = bus.PWDATA;
    if (!PRESETn) tb_last = 1'b1;
    else if (a0)  tb_last = 1'b0;
    else if (a1)  tb_last = 1'b1;
  end

  task automatic drain(input int max_cyc, input string tag);
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge PCLK); #1;
      if (exp_q.size() == 0 && dq0.size() == 0 && dq1.size() == 0 &&
          !d_valid[0] && !d_valid[1] && !bus.PSELx) return;
    end
    n_tests++; n_fail++;
    $display("FAIL drain_%s: transfers still pending after %0d cycles, required all complete", tag, max_cyc);
  endtask

  task automatic rand_x(output xfer_t x);
    x = '{1'b0, 1'($urandom_range(0, 1)), AW'($urandom_range(0, (1<<AW) - 1)), DW'($urandom_range(0, 255))};
  endtask

  initial begin
    xfer_t x;
    bit    seen;
    d_valid  = '{1'b0, 1'b0};
    acc_flag = '{1'b0, 1'b0};
    for (int i = 0; i < (1<<AW); i++) begin
      seed_mem[i] = DW'($urandom_range(0, 255));
      ref_mem[i]  = seed_mem[i];
    end
    repeat (3) @(posedge PCLK);
    #1 PRESETn = 1'b1;

    // single write, no wait states
    dq0.push_back('{1'b0, 1'b1, 4'h3, 8'hA5});
    drain(20, "write0");

    // read with two wait states, returns the data just written
    stall_n = 2;
    dq1.push_back('{1'b0, 1'b0, 4'h3, 8'h00});
    drain(20, "read1");
    stall_n = 0;

    // both valid from reset: alternating grants, back-to-back transfers
    @(posedge PCLK); #1 PRESETn = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rand_x(x); dq0.push_back(x);
      rand_x(x); dq1.push_back(x);
    end
    repeat (2) @(posedge PCLK);
    #1 PRESETn = 1'b1;
    drain(80, "rr");

    // reset while a req0 read sits in ACCESS
    stall_n = 10;
    dq0.push_back('{1'b0, 1'b0, 4'h5, 8'h00});
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge PCLK); #1;
      seen = bus.PSELx && bus.PENABLE;
    end
    chk("reach_access", seen, 1'b1);
    @(posedge PCLK); #1 PRESETn = 1'b0;
    dq0.push_back('{1'b0, 1'b0, 4'h6, 8'h00});
    dq1.push_back('{1'b0, 1'b1, 4'h6, 8'h3C});
    stall_n = 0;
    @(posedge PCLK); #1 PRESETn = 1'b1;
    drain(40, "after_reset");

    // PREADY stuck low: without the timeout option ACCESS waits forever
    ready_pct = 0;
    dq0.push_back('{1'b0, 1'b0, 4'h6, 8'h00});
    repeat (105) @(negedge PCLK);
    #1;
    chk("stuck_access_ctl", {bus.PSELx, bus.PENABLE}, 2'b11);
    chk("stuck_rsp_err", {bus.rsp0_err, bus.rsp1_err}, 2'b00);
    chk("stuck_pending", exp_q.size(), 1);
    ready_pct = 100;
    drain(20, "stuck_release");

    // random traffic with random wait states
    rnd_en    = 1'b1;
    valid_pct = 60;
    ready_pct = 60;
    repeat (2000) @(posedge PCLK);
    rnd_en    = 1'b0;
    ready_pct = 100;
    drain(200, "random");
    chk("final_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule
